// File: rtl/midi_rx_parser_pkg.sv
// Shared MIDI definitions for the MIDI IN receive path.
//  - status byte constants used by the parser and by midi_ctrl
//  - midi_data_len(): number of data bytes a channel status expects
//  - midi_msg_t: one fully decoded message (status, data1, data2, len)
//  - uart_state_e: byte-level receiver states
package midi_rx_parser_pkg;

  localparam logic [7:0] NOTE_ON    = 8'h90;
  localparam logic [7:0] CC_MSG     = 8'hB0;
  localparam logic [7:0] PC_MSG     = 8'hC0;
  localparam logic [7:0] SYS_COMMON = 8'hF0;
  localparam logic [7:0] RT_CLOCK   = 8'hF8;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  // Program change (0xC_) and channel pressure (0xD_) carry one data byte,
  // every other channel message carries two. Non-channel bytes return 0.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
      len = 2'd1;
    end else if (status[7] && status[7:4] != 4'hF) begin
      len = 2'd2;
    end else begin
      len = 2'd0;
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Decoded-message bus from the MIDI IN parser to the learn/assign logic.
//  msg_valid   : one-cycle strobe, msg_* hold a complete message
//  msg_status  : status byte
//  msg_data1   : first data byte (0 if unused)
//  msg_data2   : second data byte (0 if unused)
//  msg_len     : bytes in the message including status (1..3)
//  framing_err : one-cycle strobe, a byte was dropped for a bad stop bit
// master = parser (drives), slave = consumer (observes).
interface midi_rx_parser_if;

  logic       msg_valid;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic [1:0] msg_len;
  logic       framing_err;

  modport master (
    output msg_valid, msg_status, msg_data1, msg_data2, msg_len, framing_err
  );

  modport slave (
    input msg_valid, msg_status, msg_data1, msg_data2, msg_len, framing_err
  );

endinterface

// File: rtl/midi_rx_parser_uart_rx.sv
// midi_uart_rx: 8N1 serial byte receiver for the MIDI IN line.
//  clk            : system clock
//  rst            : synchronous active-low reset
//  midi_rx_i      : raw serial line, idle high, asynchronous to clk
//  rx_byte_o      : last received byte, valid while byte_valid_o is high
//  byte_valid_o   : one-cycle strobe, a byte with a good stop bit arrived
//  framing_err_o  : one-cycle strobe, stop bit sampled low, byte dropped
// The input synchroniser lives here; sampling is done at mid-bit.
module midi_uart_rx
  import midi_rx_parser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       framing_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  uart_state_e            state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_idx_q;
  logic                   stop_wait_q;
  logic                   byte_valid_q;
  logic                   ferr_q;
  logic [7:0]             shift_q;
  logic                   sample_data;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign sample_data = (state_q == U_DATA) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q       <= '1;
      state_q      <= U_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_wait_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], midi_rx_i};
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      case (state_q)
        U_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_BIT;
            state_q <= U_START;
          end
        end
        U_START: begin
          if (cnt_q == '0) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_s) begin
              state_q <= U_IDLE;
            end else begin
              cnt_q     <= FULL_BIT;
              bit_idx_q <= '0;
              state_q   <= U_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        U_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= FULL_BIT;
            if (bit_idx_q == 3'd7) begin
              state_q <= U_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        U_STOP: begin
          if (stop_wait_q) begin
            // After a framing error, hold off until the line is idle again
            // so the low stop bit is not mistaken for a new start bit.
            if (rx_s) begin
              stop_wait_q <= 1'b0;
              state_q     <= U_IDLE;
            end
          end else if (cnt_q == '0) begin
            if (rx_s) begin
              byte_valid_q <= 1'b1;
              state_q      <= U_IDLE;
            end else begin
              ferr_q      <= 1'b1;
              stop_wait_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= U_IDLE;
      endcase
    end
  end

  // Data shift register: LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (sample_data) begin
      shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  assign rx_byte_o     = shift_q;
  assign byte_valid_o  = byte_valid_q;
  assign framing_err_o = ferr_q;

endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: MIDI IN receiver assembling complete channel messages.
//  clk      : system clock
//  rst      : synchronous active-low reset
//  midi_rx  : raw MIDI serial line, idle high, asynchronous to clk
//  msg_if   : master side of the decoded-message bus (msg_valid, msg_status,
//             msg_data1, msg_data2, msg_len, framing_err)
// Handles running status and real-time bytes interleaved inside messages.
// This level holds only the message parser and the output registers.
module midi_rx_parser
  import midi_rx_parser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               midi_rx,
  midi_rx_parser_if.master   msg_if
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       uart_ferr;

  midi_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_uart (
    .clk           (clk),
    .rst           (rst),
    .midi_rx_i     (midi_rx),
    .rx_byte_o     (rx_byte),
    .byte_valid_o  (byte_valid),
    .framing_err_o (uart_ferr)
  );

  // Running status of 0 means "none": valid statuses always have bit 7 set.
  logic [7:0] running_q, running_d;
  logic       pend_q, pend_d;
  logic [7:0] data1_q, data1_d;
  logic       emit_d;
  midi_msg_t  emit_msg_d;
  logic       valid_q;
  midi_msg_t  msg_q;
  logic       ferr_q;

  always_comb begin
    running_d  = running_q;
    pend_d     = pend_q;
    data1_d    = data1_q;
    emit_d     = 1'b0;
    emit_msg_d = '{status: rx_byte, data1: 8'h00, data2: 8'h00, len: 2'd1};
    if (byte_valid) begin
      if (rx_byte >= RT_CLOCK) begin
        // Real-time bytes pass straight through without disturbing a
        // message that is being assembled around them.
        emit_d = 1'b1;
      end else if (rx_byte >= SYS_COMMON) begin
        running_d = 8'h00;
        pend_d    = 1'b0;
      end else if (rx_byte[7]) begin
        running_d = rx_byte;
        pend_d    = 1'b0;
      end else if (running_q != 8'h00) begin
        if (!pend_q && midi_data_len(running_q) == 2'd2) begin
          data1_d = rx_byte;
          pend_d  = 1'b1;
        end else begin
          emit_d = 1'b1;
          pend_d = 1'b0;
          if (midi_data_len(running_q) == 2'd1) begin
            emit_msg_d = '{status: running_q, data1: rx_byte,
                           data2: 8'h00, len: 2'd2};
          end else begin
            emit_msg_d = '{status: running_q, data1: data1_q,
                           data2: rx_byte, len: 2'd3};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      running_q <= 8'h00;
      pend_q    <= 1'b0;
      data1_q   <= 8'h00;
      valid_q   <= 1'b0;
      msg_q     <= '0;
      ferr_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      pend_q    <= pend_d;
      data1_q   <= data1_d;
      valid_q   <= emit_d;
      ferr_q    <= uart_ferr;
      if (emit_d) begin
        msg_q <= emit_msg_d;
      end
    end
  end

  assign msg_if.msg_valid   = valid_q;
  assign msg_if.msg_status  = msg_q.status;
  assign msg_if.msg_data1   = msg_q.data1;
  assign msg_if.msg_data2   = msg_q.data2;
  assign msg_if.msg_len     = msg_q.len;
  assign msg_if.framing_err = ferr_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Testbench for midi_rx_parser at 16 clocks per MIDI bit.
module tb_midi_rx_parser;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic midi_rx;

  midi_rx_parser_if bus ();

  midi_rx_parser #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .midi_rx (midi_rx),
    .msg_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-level reference model: running status plus a list of data bytes.
  exp_t       exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] m_rs = 8'h00;
  logic [7:0] m_data[$];

  // Observed history from the compare process.
  int         n_msgs = 0;
  int         n_ferr = 0;
  exp_t       last;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    exp_t e;
    if (b >= 8'hF8) begin
      e = '{s: b, d1: 8'h00, d2: 8'h00, len: 2'd1};
      exp_q.push_back(e);
    end else if (b >= 8'hF0) begin
      m_rs = 8'h00;
      m_data.delete();
    end else if (b[7]) begin
      m_rs = b;
      m_data.delete();
    end else if (m_rs != 8'h00) begin
      m_data.push_back(b);
      need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
      if (m_data.size() == need) begin
        e.s   = m_rs;
        e.d1  = m_data[0];
        e.d2  = (need == 2) ? m_data[1] : 8'h00;
        e.len = 2'(need + 1);
        exp_q.push_back(e);
        m_data.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) model_byte(b);
    else exp_ferr++;
    midi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_and_drain(input string name);
    repeat (3 * CPB) @(negedge clk);
    check({name, "_drain_msgs"}, exp_q.size(), 0);
    check({name, "_drain_ferr"}, exp_ferr, 0);
  endtask

  task automatic check_last(input string name, input logic [7:0] s,
                            input logic [7:0] d1, input logic [7:0] d2,
                            input logic [1:0] len);
    check({name, "_status"}, last.s, s);
    check({name, "_data1"},  last.d1, d1);
    check({name, "_data2"},  last.d2, d2);
    check({name, "_len"},    last.len, len);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"},  bus.msg_valid, 0);
    check({name, "_ferr"},   bus.framing_err, 0);
    check({name, "_status"}, bus.msg_status, 0);
    check({name, "_data1"},  bus.msg_data1, 0);
    check({name, "_data2"},  bus.msg_data2, 0);
    check({name, "_len"},    bus.msg_len, 0);
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_t e;
      n_checks++;
      if (bus.msg_valid === 1'b1 && bus.framing_err === 1'b1) begin
        n_fail++;
        $display("FAIL valid_and_ferr: both high, required at most one");
      end
      if (bus.msg_valid === 1'b1) begin
        n_msgs++;
        last = '{s: bus.msg_status, d1: bus.msg_data1,
                 d2: bus.msg_data2, len: bus.msg_len};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_msg: got %h %h %h len %0d, required none",
                   bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len);
        end else begin
          e = exp_q.pop_front();
          if (bus.msg_status !== e.s || bus.msg_data1 !== e.d1 ||
              bus.msg_data2 !== e.d2 || bus.msg_len !== e.len) begin
            n_fail++;
            $display("FAIL msg: got %h %h %h len %0d, required %h %h %h len %0d",
                     bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len,
                     e.s, e.d1, e.d2, e.len);
          end
        end
      end
      if (bus.framing_err === 1'b1) begin
        n_ferr++;
        n_checks++;
        if (exp_ferr == 0) begin
          n_fail++;
          $display("FAIL unexpected_framing_err: got 1, required 0");
        end else begin
          exp_ferr--;
        end
      end
    end
  end

  initial begin
    int m0;
    int f0;
    rst     = 1'b0;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");

    // 1: complete control change
    m0 = n_msgs;
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h7F, 1'b1);
    idle_and_drain("t1");
    check("t1_count", n_msgs - m0, 1);
    check_last("t1", 8'hB0, 8'h2E, 8'h7F, 2'd3);

    // 2: program change with running status
    m0 = n_msgs;
    send_byte(8'hC0, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    idle_and_drain("t2");
    check("t2_count", n_msgs - m0, 2);
    check_last("t2", 8'hC0, 8'h43, 8'h00, 2'd2);

    // 3: real-time clock inside a note-on
    m0 = n_msgs;
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h64, 1'b1);
    idle_and_drain("t3");
    check("t3_count", n_msgs - m0, 2);
    check_last("t3", 8'h90, 8'h3C, 8'h64, 2'd3);

    // 4: framing error, then a good message
    m0 = n_msgs;
    f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("t4_ferr_count", n_ferr - f0, 1);
    check("t4_no_msg", n_msgs - m0, 0);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle_and_drain("t4");
    check("t4_count", n_msgs - m0, 1);
    check_last("t4", 8'hB0, 8'h01, 8'h02, 2'd3);

    // 5: clear running status with a system common byte, then orphan data
    //    bytes and a short low glitch
    m0 = n_msgs;
    f0 = n_ferr;
    send_byte(8'hF6, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h40, 1'b1);
    midi_rx = 1'b0;
    repeat (4) @(negedge clk);
    midi_rx = 1'b1;
    idle_and_drain("t5");
    check("t5_no_msg", n_msgs - m0, 0);
    check("t5_no_ferr", n_ferr - f0, 0);

    // 6: reset in the middle of a message
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rs = 8'h00;
    m_data.delete();
    check_outputs_zero("t6_reset");
    m0 = n_msgs;
    send_byte(8'h7F, 1'b1);
    send_byte(8'h7F, 1'b1);
    idle_and_drain("t6");
    check("t6_no_msg", n_msgs - m0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
